mips_main_ctrl: RTL and testbench
=================================

# mips_main_ctrl

Multi-cycle main control FSM for the MIPS CPU. It fetches each instruction over the instruction-memory handshake and latches it in the instruction register. It decodes the type and opcode fields into the `alu_op` / `instr_type` pair consumed by the ALU control stage, then sequences execute, memory and write-back for R-type, I-type, BEQ and jump instructions. It sits between instruction/data memory and the datapath, and is the producer side of the ALU-control interface.

## Interface
- `DATA_W`, 32: instruction width.
- `OP_W`, 4: ALU opcode width, equal to the ALU control `ControlSize`.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `imem_rdata` in DATA_W: instruction word, valid while `imem_ack` is high.
- `imem_req` out 1: instruction fetch request.
- `imem_ack` in 1: instruction fetch complete.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data write (SWI); 0 means read (LWI).
- `dmem_ack` in 1: data access complete.
- `alu_zero` in 1: ALU zero flag, used for BEQ.
- `alu_op` out OP_W: the IR field [29:26], except SUB (4'b0011) for BEQ.
- `instr_type` out 2: the IR field [31:30]; 0=R, 1=J, 2=BEQ, 3=I.
- `ir_we` out 1: instruction register load strobe.
- `pc_we` out 1: PC write strobe.
- `pc_src` out 2: 0=PC+4, 1=branch target, 2=jump target.
- `reg_we` out 1: register file write strobe.
- `wb_sel` out 1: 0=ALU result, 1=memory data.
- `illegal` out 1: illegal-opcode flag (see Configuration).

## Operation
- Legal opcodes: ADD 0010, SUB 0011, OR 0100, AND 0101, XOR 0110, SLT 0111, LI 1001, LWI 1011, SWI 1100.
  - R-type accepts ADD through SLT only.
  - I-type accepts all nine.
  - BEQ and J ignore the opcode field.
- **IDLE:** entered on reset; goes unconditionally to FETCH on the next clock.
- **FETCH:** `imem_req`=1 until `imem_ack`. On the ack cycle, `ir_we`=1, `pc_we`=1 and `pc_src`=0; then go to DECODE.
- **DECODE:** register read takes one cycle.
  - Illegal opcode: handled per Configuration.
  - Otherwise go to EXEC.
- **EXEC:** one cycle.
  - BEQ: `pc_we`=`alu_zero`, `pc_src`=1; then FETCH.
  - J: `pc_we`=1, `pc_src`=2; then FETCH.
  - LWI and SWI: go to MEM.
  - All others: go to WB.
- **MEM:** `dmem_req`=1 and `dmem_we`=(op==SWI), both held until `dmem_ack`.
  - LWI: go to WB.
  - SWI: go to FETCH.
- **WB:** `reg_we`=1, `wb_sel`=(op==LWI); then FETCH.
- All strobes (`ir_we`, `pc_we`, `reg_we`, `dmem_req`, `imem_req`) are Moore/Mealy decodes of the state and are zero in every state not listed above.
- `alu_op` and `instr_type` are combinational from the IR and stable from DECODE until the next `ir_we`.

## Timing
- Reset values: state IDLE, IR=0, every output 0 (`alu_op`=0, `instr_type`=0, `illegal`=0).
- The first `imem_req` appears in the second cycle after `rst_n` rises.
- Minimum cycles per instruction, with zero-wait memory (ack in the request cycle):
  - BEQ and J: 3.
  - R-type, I-type ALU and SWI: 4.
  - LWI: 5.
  - Each ack wait cycle adds one cycle.
- `imem_ack`/`dmem_ack` high outside the matching request state is ignored.
- Asserting `rst_n` mid-FSM forces IDLE and zeroes all outputs immediately. Any outstanding memory request is abandoned, and memory must tolerate a dropped request.
- `pc_we` and `reg_we` are never high in the same cycle.

## Configuration
- `MAIN_CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in DECODE goes to a HALT state.
  - `illegal`=1 and stays high until reset; no further requests or strobes are issued.
- Macro undefined:
  - An illegal opcode is a NOP: DECODE goes directly to FETCH with no `reg_we`/`dmem_req`.
  - HALT is absent and `illegal` is tied to 0.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the FSM state enum;
  - ALU opcode constants (shared with the ALU control stage);
  - instruction-type constants;
  - `pc_src` and `wb_sel` encodings.
- One sub-module, `mips_op_classify` (combinational), takes type and opcode and returns legal, is_mem, is_store, is_branch and is_jump.

## Test plan
- Reset: hold `rst_n` low for 3 cycles → all outputs 0. After release, `imem_req`=1 exactly in the second cycle.
- R-type ADD (0x08000000), ack in the same cycle → `alu_op`=0010, `instr_type`=0, `reg_we` one pulse 3 cycles after `ir_we` with `wb_sel`=0.
- LWI (0xEC000000), `dmem_ack` delayed 3 cycles → `dmem_req` high for 4 cycles with `dmem_we`=0, then `reg_we`=1 with `wb_sel`=1 on the next cycle.
- BEQ (0x80000000):
  - `alu_zero`=1 → EXEC cycle has `pc_we`=1, `pc_src`=1, `alu_op`=0011.
  - `alu_zero`=0 → no EXEC `pc_we`.
- Illegal R-type LI (0x24000000):
  - With the macro → `illegal`=1, no further `imem_req`.
  - Without the macro → no `reg_we`, next `imem_req` one cycle after DECODE.
- SWI in MEM with `rst_n` dropped before `dmem_ack` → `dmem_req`/`dmem_we` drop to 0 asynchronously and the FSM restarts from IDLE.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS main control FSM and the ALU control stage.
// MAIN_CTRL_ILLEGAL_TRAP_EN adds the HALT state used to trap illegal opcodes.
package mips_ctrl_pkg;

`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB
  } state_e;
`endif

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_LI  = 4'b1001;
  localparam logic [3:0] ALU_LWI = 4'b1011;
  localparam logic [3:0] ALU_SWI = 4'b1100;

  localparam logic [1:0] TYPE_R   = 2'd0;
  localparam logic [1:0] TYPE_J   = 2'd1;
  localparam logic [1:0] TYPE_BEQ = 2'd2;
  localparam logic [1:0] TYPE_I   = 2'd3;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

endpackage

// File: rtl/mips_op_classify.sv
// Combinational decode of instruction type + opcode into legality and class flags.
module mips_op_classify
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] instr_type,
  input  logic [3:0] op,
  output logic       legal,
  output logic       is_mem,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jump
);

  logic r_ok;
  logic i_ok;

  // R-type only carries register-register ALU ops; I-type adds LI and the memory ops.
  assign r_ok = (op >= ALU_ADD) && (op <= ALU_SLT);
  assign i_ok = r_ok || (op == ALU_LI) || (op == ALU_LWI) || (op == ALU_SWI);

  assign is_branch = (instr_type == TYPE_BEQ);
  assign is_jump   = (instr_type == TYPE_J);
  assign is_mem    = (instr_type == TYPE_I) && ((op == ALU_LWI) || (op == ALU_SWI));
  assign is_store  = (instr_type == TYPE_I) && (op == ALU_SWI);
  assign legal     = is_branch || is_jump ||
                     ((instr_type == TYPE_R) && r_ok) ||
                     ((instr_type == TYPE_I) && i_ok);

endmodule

// File: rtl/mips_main_ctrl.sv
// Multi-cycle MIPS main control: fetch/decode/exec/mem/wb, 3-5 cycles per instruction plus ack waits.
// Strobes are state decodes qualified by acks; MAIN_CTRL_ILLEGAL_TRAP_EN traps illegal opcodes in HALT.
module mips_main_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              imem_req,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  input  logic              alu_zero,
  output logic [OP_W-1:0]   alu_op,
  output logic [1:0]        instr_type,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_src,
  output logic              reg_we,
  output logic              wb_sel,
  output logic              illegal
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              legal, is_mem, is_store, is_branch, is_jump;
  logic              unused_ir;

  assign instr_type = ir_q[31:30];
  assign alu_op     = is_branch ? OP_W'(ALU_SUB) : OP_W'(ir_q[29:26]);
  assign unused_ir  = ^ir_q[DATA_W-7:0];

  mips_op_classify u_classify (
    .instr_type (ir_q[31:30]),
    .op         (ir_q[29:26]),
    .legal      (legal),
    .is_mem     (is_mem),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .is_jump    (is_jump)
  );

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PC_SRC_SEQ;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = WB_ALU;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!legal) begin
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
          state_d = ST_HALT;
`else
          state_d = ST_FETCH;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_branch) begin
          pc_we   = alu_zero;
          pc_src  = PC_SRC_BR;
          state_d = ST_FETCH;
        end else if (is_jump) begin
          pc_we   = 1'b1;
          pc_src  = PC_SRC_JMP;
          state_d = ST_FETCH;
        end else if (is_mem) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) state_d = is_store ? ST_FETCH : ST_WB;
      end
      ST_WB: begin
        reg_we  = 1'b1;
        wb_sel  = (is_mem && !is_store) ? WB_MEM : WB_ALU;
        state_d = ST_FETCH;
      end
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
  assign illegal = (state_q == ST_HALT);
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_mips_main_ctrl.sv
// Bench for mips_main_ctrl: per-instruction cycle expectations built from the instruction rules.
module tb_mips_main_ctrl;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DATA_W-1:0] imem_rdata = '0;
  logic              imem_req, imem_ack = 1'b0;
  logic              dmem_req, dmem_we, dmem_ack = 1'b0;
  logic              alu_zero = 1'b0;
  logic [OP_W-1:0]   alu_op;
  logic [1:0]        instr_type, pc_src;
  logic              ir_we, pc_we, reg_we, wb_sel, illegal;

  mips_main_ctrl #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n), .imem_rdata(imem_rdata), .imem_req(imem_req),
    .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_zero(alu_zero), .alu_op(alu_op), .instr_type(instr_type), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ireq, irwe, pcwe;
    logic [1:0] pcsrc;
    logic       pcsrc_v, dreq, dwe, regwe, wbsel;
  } exp_t;

  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_alu = 4'd0;
  logic [1:0] exp_type = 2'd0;
  logic       exp_ill = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit legal_f(input logic [1:0] t, input logic [3:0] op);
    if (t == 2'd1 || t == 2'd2) return 1'b1;
    if (t == 2'd0) return (op >= 4'd2 && op <= 4'd7);
    return (op >= 4'd2 && op <= 4'd7) || op == 4'b1001 || op == 4'b1011 || op == 4'b1100;
  endfunction

  task automatic check_zero(input string pfx);
    chk({pfx, "_imem_req"},   32'(imem_req),   32'd0);
    chk({pfx, "_ir_we"},      32'(ir_we),      32'd0);
    chk({pfx, "_pc_we"},      32'(pc_we),      32'd0);
    chk({pfx, "_pc_src"},     32'(pc_src),     32'd0);
    chk({pfx, "_dmem_req"},   32'(dmem_req),   32'd0);
    chk({pfx, "_dmem_we"},    32'(dmem_we),    32'd0);
    chk({pfx, "_reg_we"},     32'(reg_we),     32'd0);
    chk({pfx, "_wb_sel"},     32'(wb_sel),     32'd0);
    chk({pfx, "_alu_op"},     32'(alu_op),     32'd0);
    chk({pfx, "_instr_type"}, 32'(instr_type), 32'd0);
    chk({pfx, "_illegal"},    32'(illegal),    32'd0);
  endtask

  // Drive one cycle's inputs just after the edge, check outputs on the falling edge.
  task automatic cyc(input logic ia, input logic da, input logic z, input logic [31:0] rd, input exp_t e);
    @(posedge clk); #1;
    imem_ack = ia; dmem_ack = da; alu_zero = z; imem_rdata = rd;
    @(negedge clk);
    chk("imem_req", 32'(imem_req), 32'(e.ireq));
    chk("ir_we",    32'(ir_we),    32'(e.irwe));
    chk("pc_we",    32'(pc_we),    32'(e.pcwe));
    chk("dmem_req", 32'(dmem_req), 32'(e.dreq));
    chk("reg_we",   32'(reg_we),   32'(e.regwe));
    if (e.pcsrc_v) chk("pc_src", 32'(pc_src), 32'(e.pcsrc));
    if (e.dreq) chk("dmem_we", 32'(dmem_we), 32'(e.dwe));
    if (e.regwe) chk("wb_sel", 32'(wb_sel), 32'(e.wbsel));
    chk("alu_op",     32'(alu_op),     32'(exp_alu));
    chk("instr_type", 32'(instr_type), 32'(exp_type));
    chk("illegal",    32'(illegal),    32'(exp_ill));
  endtask

  task automatic do_reset(input bit mid);
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; alu_zero = 1'b0;
    #1;
    if (mid) check_zero("rst_async");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst_hold");
    exp_alu = 4'd0; exp_type = 2'd0; exp_ill = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle");
  endtask

  task automatic run_instr(input logic [31:0] instr, input int fw, input int mw,
                           input logic z, input bit rst_mid);
    logic [1:0] t;
    logic [3:0] op;
    exp_t       e;
    t  = instr[31:30];
    op = instr[29:26];
    for (int i = 0; i < fw; i++) begin
      e = '0; e.ireq = 1'b1;
      cyc(1'b0, 1'($urandom), 1'($urandom), $urandom, e);
    end
    e = '0; e.ireq = 1'b1; e.irwe = 1'b1; e.pcwe = 1'b1; e.pcsrc_v = 1'b1; e.pcsrc = 2'd0;
    cyc(1'b1, 1'($urandom), 1'($urandom), instr, e);
    exp_type = t;
    exp_alu  = (t == 2'd2) ? 4'b0011 : op;
    e = '0;
    cyc(1'($urandom), 1'($urandom), 1'($urandom), $urandom, e);
    if (!legal_f(t, op)) begin
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
      exp_ill = 1'b1;
      repeat (5) cyc(1'($urandom), 1'($urandom), 1'($urandom), $urandom, '0);
`endif
      return;
    end
    e = '0;
    if (t == 2'd1) begin
      e.pcwe = 1'b1; e.pcsrc_v = 1'b1; e.pcsrc = 2'd2;
      cyc(1'($urandom), 1'($urandom), 1'($urandom), $urandom, e);
      return;
    end
    if (t == 2'd2) begin
      e.pcwe = z; e.pcsrc_v = 1'b1; e.pcsrc = 2'd1;
      cyc(1'($urandom), 1'($urandom), z, $urandom, e);
      return;
    end
    cyc(1'($urandom), 1'($urandom), 1'($urandom), $urandom, e);
    if (t == 2'd3 && (op == 4'b1011 || op == 4'b1100)) begin
      e = '0; e.dreq = 1'b1; e.dwe = (op == 4'b1100);
      for (int i = 0; i < mw; i++) begin
        if (rst_mid && i == 1) begin
          @(posedge clk); #1;
          do_reset(1'b1);
          return;
        end
        cyc(1'($urandom), 1'b0, 1'($urandom), $urandom, e);
      end
      cyc(1'($urandom), 1'b1, 1'($urandom), $urandom, e);
      if (op == 4'b1100) return;
    end
    e = '0; e.regwe = 1'b1; e.wbsel = (t == 2'd3 && op == 4'b1011);
    cyc(1'($urandom), 1'($urandom), 1'($urandom), $urandom, e);
  endtask

  initial begin
    logic [3:0] legal_i [9];
    logic [1:0] rt;
    logic [3:0] rop;
    legal_i = '{4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1011, 4'b1100};

    do_reset(1'b0);
    run_instr(32'h0800_0000, 0, 0, 1'b0, 1'b0);   // ADD, zero-wait
    run_instr(32'hEC00_0000, 1, 3, 1'b0, 1'b0);   // LWI, dmem_ack after 3 waits
    run_instr(32'h8000_0000, 0, 0, 1'b1, 1'b0);   // BEQ taken
    run_instr(32'h8000_0000, 2, 0, 1'b0, 1'b0);   // BEQ not taken
    run_instr(32'h4000_1234, 0, 0, 1'b0, 1'b0);   // J
    run_instr(32'h2400_0000, 0, 0, 1'b0, 1'b0);   // R-type LI is illegal
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    do_reset(1'b0);
`endif
    for (int n = 0; n < 200; n++) begin
      rt = 2'($urandom);
      if ($urandom_range(0, 7) == 0) rop = 4'($urandom);
      else if (rt == 2'd0) rop = 4'($urandom_range(2, 7));
      else rop = legal_i[$urandom_range(0, 8)];
      run_instr({rt, rop, 26'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'b0);
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
      if (!legal_f(rt, rop)) do_reset(1'b0);
`endif
    end
    run_instr(32'hF000_0000, 0, 3, 1'b0, 1'b1);   // SWI with reset during MEM wait
    run_instr(32'h0C00_0000, 0, 0, 1'b0, 1'b0);   // SUB after restart
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
